// File: rtl/accum_ctrl.sv
// Accumulator-table sequencer: diagonally skewed per-column read/write/clear streams for one tile pass.
// Optional busy-cycle counter enabled by defining ACCUM_CTRL_PERF_EN.
module accum_ctrl #(
  parameter int SYS_ARR_COLS = 16,
  parameter int MAX_ROWS_NUM = 128,
  parameter int MAX_OUT_COLS = 128,
  parameter int RMW_LAT      = 2,
  localparam int NUM_ACCUM_ROWS = MAX_ROWS_NUM * (MAX_OUT_COLS / SYS_ARR_COLS),
  localparam int AW = $clog2(NUM_ACCUM_ROWS),
  localparam int RW = $clog2(MAX_ROWS_NUM) + 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       accumulate,
  input  logic [AW-1:0]              base_addr,
  input  logic [RW-1:0]              num_rows,
  input  logic                       clear_req,
  output logic                       busy,
  output logic                       done,
  output logic [SYS_ARR_COLS-1:0]    clear,
  output logic [SYS_ARR_COLS-1:0]    rd_en,
  output logic [SYS_ARR_COLS-1:0]    wr_en,
  output logic [AW*SYS_ARR_COLS-1:0] rd_address,
  output logic [AW*SYS_ARR_COLS-1:0] wr_address,
  output logic [31:0]                perf_cycles
);

  localparam int C  = SYS_ARR_COLS;
  localparam int KW = $clog2(MAX_ROWS_NUM + SYS_ARR_COLS + RMW_LAT) + 1;

  typedef enum logic [1:0] {IDLE, RUN, CLEAR, DONE} state_t;

  state_t         state_q, state_d;
  logic           acc_q;
  logic [RW-1:0]  rows_q;
  logic [AW-1:0]  row_q;
  logic [KW-1:0]  k_q;
  logic [KW-1:0]  run_last;
  logic           src_vld;
  logic           row_last;

  logic [C-2:0]   skv_q;
  logic [AW-1:0]  ska_q [C-1];
  logic [C-1:0]   col_vld;
  logic [AW-1:0]  col_adr [C];

  logic [RMW_LAT-1:0] wv_q [C];
  logic [AW-1:0]      wa_q [C][RMW_LAT];

  function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] a);
    if (a == AW'(NUM_ACCUM_ROWS - 1)) return '0;
    return a + AW'(1);
  endfunction

  // Last RUN cycle: final row of the last column written back.
  assign run_last = KW'(rows_q) + KW'(C + RMW_LAT - 2);
  assign src_vld  = (state_q == RUN) && (k_q < KW'(rows_q));
  assign row_last = (k_q + KW'(1)) >= KW'(rows_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (start)          state_d = RUN;
        else if (clear_req) state_d = CLEAR;
      end
      RUN:     if (rows_q == '0 || k_q == run_last) state_d = DONE;
      CLEAR:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    clear = '0;
    unique case (state_q)
      RUN:   busy = 1'b1;
      CLEAR: begin
        busy  = 1'b1;
        clear = '1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= 1'b0;
      rows_q <= '0;
      row_q  <= '0;
      k_q    <= '0;
    end else if (state_q == IDLE && start) begin
      acc_q  <= accumulate;
      rows_q <= num_rows;
      row_q  <= base_addr;
      k_q    <= '0;
    end else if (state_q == RUN) begin
      k_q <= k_q + KW'(1);
      // Stop advancing on the final row so column 0's address holds its last value.
      if (src_vld && !row_last) row_q <= wrap_inc(row_q);
    end
  end

  // Diagonal skew: column c sees column 0's row stream delayed by c cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skv_q <= '0;
      for (int c = 0; c < C - 1; c++) ska_q[c] <= '0;
    end else begin
      skv_q[0] <= src_vld;
      if (src_vld) ska_q[0] <= row_q;
      for (int c = 1; c < C - 1; c++) begin
        skv_q[c] <= skv_q[c-1];
        if (skv_q[c-1]) ska_q[c] <= ska_q[c-1];
      end
    end
  end

  assign col_vld = {skv_q, src_vld};

  // Write side trails each column's read by RMW_LAT cycles, issued regardless of mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < C; c++) begin
        wv_q[c] <= '0;
        for (int j = 0; j < RMW_LAT; j++) wa_q[c][j] <= '0;
      end
    end else begin
      for (int c = 0; c < C; c++) begin
        wv_q[c][0] <= col_vld[c];
        if (col_vld[c]) wa_q[c][0] <= col_adr[c];
        for (int j = 1; j < RMW_LAT; j++) begin
          wv_q[c][j] <= wv_q[c][j-1];
          if (wv_q[c][j-1]) wa_q[c][j] <= wa_q[c][j-1];
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < C; gi++) begin : g_col
      if (gi == 0) begin : g_src
        assign col_adr[gi] = row_q;
      end else begin : g_skew
        assign col_adr[gi] = ska_q[gi-1];
      end
      assign rd_en[gi]                  = col_vld[gi] & acc_q;
      assign wr_en[gi]                  = wv_q[gi][RMW_LAT-1];
      assign rd_address[AW*gi +: AW]    = col_adr[gi];
      assign wr_address[AW*gi +: AW]    = wa_q[gi][RMW_LAT-1];
    end
  endgenerate

`ifdef ACCUM_CTRL_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    perf_q <= '0;
    else if (busy && perf_q != '1) perf_q <= perf_q + 32'd1;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = '0;
`endif

endmodule

// File: tb/tb_accum_ctrl.sv
// Self-checking bench for accum_ctrl: table of directed passes, hand-written corner sequences,
// and randomized passes checked against an arithmetic model of the skewed row schedule.
module tb_accum_ctrl;

  localparam int C     = 16;
  localparam int L     = 2;
  localparam int AW    = 10;
  localparam int RW    = 8;
  localparam int NROWS = 1024;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              accumulate;
  logic [AW-1:0]     base_addr;
  logic [RW-1:0]     num_rows;
  logic              clear_req;
  logic              busy;
  logic              done;
  logic [C-1:0]      clear;
  logic [C-1:0]      rd_en;
  logic [C-1:0]      wr_en;
  logic [AW*C-1:0]   rd_address;
  logic [AW*C-1:0]   wr_address;
  logic [31:0]       perf_cycles;

  int checks = 0;
  int errors = 0;

  accum_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .accumulate (accumulate),
    .base_addr  (base_addr),
    .num_rows   (num_rows),
    .clear_req  (clear_req),
    .busy       (busy),
    .done       (done),
    .clear      (clear),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .rd_address (rd_address),
    .wr_address (wr_address),
    .perf_cycles(perf_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL timeout act=running exp=finished");
    $fatal(1, "timeout");
  end

  typedef struct {
    bit is_clr;
    bit acc;
    int base;
    int rows;
    int inj;
    bit both;
    int exp_busy;
    int exp_c0_last;
  } vec_t;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_pass(input bit acc, input int base, input int rows, input int inj,
                         input bit both, output int busy_len, output int c0_last);
    int run_len;
    logic [31:0] p0;
    logic [C-1:0] er, ew;
    logic [AW*C-1:0] ram, rae, wam, wae;
    run_len = (rows == 0) ? 1 : rows + C - 1 + L;
    p0 = perf_cycles;
    start = 1'b1; accumulate = acc; base_addr = AW'(base); num_rows = RW'(rows);
    clear_req = both;
    step();
    start = 1'b0; clear_req = 1'b0;
    busy_len = 0; c0_last = -1;
    for (int k = 0; k < run_len; k++) begin
      if (k == inj) begin
        start = 1'b1; accumulate = ~acc; base_addr = AW'(base ^ 3); num_rows = RW'(5);
      end else begin
        start = 1'b0;
      end
      er = '0; ew = '0; ram = '0; rae = '0; wam = '0; wae = '0;
      for (int c = 0; c < C; c++) begin
        int i;
        int j;
        i = k - c;
        j = k - c - L;
        if (acc && i >= 0 && i < rows) begin
          er[c] = 1'b1;
          ram[AW*c +: AW] = '1;
          rae[AW*c +: AW] = AW'((base + i) % NROWS);
        end
        if (j >= 0 && j < rows) begin
          ew[c] = 1'b1;
          wam[AW*c +: AW] = '1;
          wae[AW*c +: AW] = AW'((base + j) % NROWS);
        end
      end
      chk("rd_en", rd_en, er);
      chk("wr_en", wr_en, ew);
      chk("rd_addr", rd_address & ram, rae);
      chk("wr_addr", wr_address & wam, wae);
      chk("clear_in_run", clear, '0);
      if (busy) busy_len++;
      if (wr_en[0]) c0_last = int'(wr_address[AW-1:0]);
      step();
    end
    start = 1'b0;
    chk("done_pulse", done, 1'b1);
    chk("busy_in_done", busy, 1'b0);
    chk("en_in_done", {rd_en, wr_en}, '0);
`ifdef ACCUM_CTRL_PERF_EN
    chk("perf", perf_cycles, p0 + 32'(run_len));
`else
    chk("perf_tied", perf_cycles, '0);
`endif
    // A start in the DONE cycle must not launch a pass.
    start = 1'b1;
    step();
    start = 1'b0;
    chk("idle_after_done", {busy, done, clear}, '0);
    $display("pass acc=%0d base=%0d rows=%0d inj=%0d both=%0d busy=%0d c0_last=%0d",
             acc, base, rows, inj, both, busy_len, c0_last);
  endtask

  task automatic do_clear(output int busy_len);
    logic [31:0] p0;
    p0 = perf_cycles;
    busy_len = 0;
    clear_req = 1'b1;
    step();
    clear_req = 1'b0;
    chk("clear_all", clear, {C{1'b1}});
    chk("clear_busy", busy, 1'b1);
    chk("clear_no_en", {rd_en, wr_en}, '0);
    if (busy) busy_len++;
    step();
    chk("clear_done", done, 1'b1);
    chk("clear_off", clear, '0);
`ifdef ACCUM_CTRL_PERF_EN
    chk("perf_clr", perf_cycles, p0 + 32'd1);
`else
    chk("perf_tied_clr", perf_cycles, '0);
`endif
    step();
    chk("clear_idle", {busy, done, clear}, '0);
    $display("clear busy=%0d", busy_len);
  endtask

  vec_t tbl[8];

  initial begin
    int bl;
    int c0;
    tbl[0] = '{0, 1,    5,   4, -1, 0,  21,    8};
    tbl[1] = '{0, 0,    5,   4, -1, 0,  21,    8};
    tbl[2] = '{0, 1, 1022,   4, -1, 0,  21,    1};
    tbl[3] = '{0, 1,  300,   0, -1, 0,   1,   -1};
    tbl[4] = '{1, 0,    0,   0, -1, 0,   1,   -1};
    tbl[5] = '{0, 1,  900, 128,  7, 0, 145,    3};
    tbl[6] = '{0, 0, 1023,   1, -1, 1,  18, 1023};
    tbl[7] = '{0, 1,    0,  16, 30, 0,  33,   15};

    rst_n = 1'b0; start = 1'b0; accumulate = 1'b0; base_addr = '0; num_rows = '0;
    clear_req = 1'b0;
    #12;
    chk("reset_ctl", {busy, done, clear, rd_en, wr_en}, '0);
    chk("reset_addr", {rd_address, wr_address}, '0);
    chk("reset_perf", perf_cycles, '0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    for (int t = 0; t < 8; t++) begin
      if (tbl[t].is_clr) begin
        do_clear(bl);
        c0 = -1;
      end else begin
        do_pass(tbl[t].acc, tbl[t].base, tbl[t].rows, tbl[t].inj, tbl[t].both, bl, c0);
      end
      chk($sformatf("tbl%0d_busy", t), bl, tbl[t].exp_busy);
      chk($sformatf("tbl%0d_c0last", t), c0, tbl[t].exp_c0_last);
    end

    // Reset asserted mid-pass at k=3.
    start = 1'b1; accumulate = 1'b1; base_addr = AW'(5); num_rows = RW'(4);
    step();
    start = 1'b0;
    step(); step(); step();
    chk("pre_rst_rd", rd_en, 16'h000F);
    chk("pre_rst_wr", wr_en, 16'h0003);
    rst_n = 1'b0;
    #1;
    chk("rst_en", {rd_en, wr_en}, '0);
    chk("rst_ctl", {busy, done, clear}, '0);
    chk("rst_perf", perf_cycles, '0);
    #20;
    rst_n = 1'b1;
    for (int n = 0; n < 25; n++) begin
      step();
      chk("post_rst_quiet", {rd_en, wr_en, done, busy}, '0);
    end
    $display("reset_mid_run checked");

    for (int r = 0; r < 12; r++) begin
      bit a;
      int b;
      int rw;
      int inj;
      a   = 1'($urandom_range(0, 1));
      b   = int'($urandom_range(0, NROWS - 1));
      rw  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 128)) : int'($urandom_range(0, 12));
      inj = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      do_pass(a, b, rw, inj, 1'($urandom_range(0, 1)), bl, c0);
      chk("rand_busy", bl, (rw == 0) ? 1 : rw + C - 1 + L);
      chk("rand_c0last", c0, (rw == 0) ? -1 : (b + rw - 1) % NROWS);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
